// File: rtl/io_dma_master.sv
// Word-copy DMA initiator on the peripheral io bus: reads one word from src, writes it to dst,
// repeats for xfer_len words; per-beat timeout, beat-boundary abort, 1-cycle done pulse.
module io_dma_master #(
    parameter int XLEN           = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 pclk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [XLEN-1:0]      src_addr,
    input  logic [XLEN-1:0]      dst_addr,
    input  logic [LEN_WIDTH-1:0] xfer_len,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic [XLEN-1:0]      io_addr,
    output logic                 io_read,
    output logic                 io_write,
    output logic                 burst,
    output logic [2:0]           burst_size,
    output logic                 read_ready,
    output logic [XLEN-1:0]      io_wdata,
    output logic [1:0]           io_byte_size,
    input  logic [XLEN-1:0]      io_rdata,
    input  logic                 io_ready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_ACK,
        S_WR_REQ,
        S_FINISH,
        S_ERR
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [XLEN-1:0]      r_src;
    logic [XLEN-1:0]      r_dst;
    logic [XLEN-1:0]      r_buf;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_words;
    logic [TW-1:0]        r_wait;
    logic                 r_abort;
    logic                 r_done;
    logic                 r_error;
    logic                 w_req;
    logic                 w_timeout;
    logic                 w_last;
    logic [LEN_WIDTH-1:0] w_words_inc;

    assign w_req       = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
    assign w_timeout   = w_req && !io_ready && (r_wait == TW'(TIMEOUT_CYCLES - 1));
    assign w_words_inc = r_words + LEN_WIDTH'(1);
    // A write that completes the block, or one with abort pending, ends the transfer.
    assign w_last      = (w_words_inc == r_len) || r_abort || abort;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = (xfer_len == '0) ? S_FINISH : S_RD_REQ;
            S_RD_REQ: if (io_ready) w_next = S_RD_ACK;
                      else if (w_timeout) w_next = S_ERR;
            S_RD_ACK: w_next = S_WR_REQ;
            S_WR_REQ: if (io_ready) w_next = w_last ? S_FINISH : S_RD_REQ;
                      else if (w_timeout) w_next = S_ERR;
            S_FINISH: w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_len   <= '0;
            r_words <= '0;
            r_wait  <= '0;
            r_abort <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done <= (r_state == S_FINISH) || (r_state == S_ERR);
            // Wait counter restarts whenever a request is entered or left.
            r_wait <= (w_req && (w_next == r_state)) ? r_wait + TW'(1) : '0;

            if (r_state == S_IDLE && start) begin
                r_src   <= src_addr;
                r_dst   <= dst_addr;
                r_len   <= xfer_len;
                r_words <= '0;
                r_error <= 1'b0;
                r_abort <= 1'b0;
            end else if (r_state != S_IDLE && abort) begin
                r_abort <= 1'b1;
            end

            if (r_state == S_RD_REQ && io_ready) r_buf <= io_rdata;

            if (r_state == S_WR_REQ && io_ready) begin
                r_words <= w_words_inc;
                r_src   <= r_src + XLEN'(4);
                r_dst   <= r_dst + XLEN'(4);
            end

            if (w_timeout) r_error <= 1'b1;
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign error        = r_error;
    assign words_done   = r_words;
    assign io_read      = (r_state == S_RD_REQ);
    assign io_write     = (r_state == S_WR_REQ);
    assign read_ready   = (r_state == S_RD_ACK);
    assign io_addr      = io_read ? r_src : (io_write ? r_dst : '0);
    assign io_wdata     = io_write ? r_buf : '0;
    assign burst        = 1'b0;
    assign burst_size   = 3'd0;
    assign io_byte_size = 2'd3;

endmodule

// File: tb/tb_io_dma_master.sv
// Bench for io_dma_master: table of transfers against a responder model (reads answer one cycle
// after the request, writes are posted) with a write scoreboard, plus idle-abort and reset sequences.
module tb_io_dma_master;

    logic        pclk;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] xfer_len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic [31:0] io_addr;
    logic        io_read;
    logic        io_write;
    logic        burst;
    logic [2:0]  burst_size;
    logic        read_ready;
    logic [31:0] io_wdata;
    logic [1:0]  io_byte_size;
    logic [31:0] io_rdata;
    logic        io_ready;

    io_dma_master dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .xfer_len     (xfer_len),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_done   (words_done),
        .io_addr      (io_addr),
        .io_read      (io_read),
        .io_write     (io_write),
        .burst        (burst),
        .burst_size   (burst_size),
        .read_ready   (read_ready),
        .io_wdata     (io_wdata),
        .io_byte_size (io_byte_size),
        .io_rdata     (io_rdata),
        .io_ready     (io_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    // Responder model
    logic [31:0] salt;
    logic        r_rd_pend;
    int          rd_beats;
    int          stall_idx;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            rd_beats  <= 0;
        end else begin
            r_rd_pend <= io_read && !io_ready;
            if (start && !busy)        rd_beats <= 0;
            else if (io_read && io_ready) rd_beats <= rd_beats + 1;
        end
    end

    always_comb begin
        io_ready = 1'b0;
        if (io_write)                                            io_ready = 1'b1;
        else if (io_read && r_rd_pend && (rd_beats != stall_idx)) io_ready = 1'b1;
    end

    always_comb io_rdata = mem_word(io_addr, salt);

    // Scoreboard: every accepted read queues the write it must turn into
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    logic [31:0] exp_src;
    logic [31:0] exp_dst;
    int          rd_cnt;
    int          wr_cnt;
    int          overlap_cnt = 0;

    always @(negedge pclk) begin
        if (rst_n) begin
            if (io_read && io_write) overlap_cnt++;
            if (io_read && io_ready) begin
                check("rd_addr", io_addr, exp_src);
                sb_q.push_back('{exp_dst, mem_word(exp_src, salt)});
                exp_src += 32'd4;
                exp_dst += 32'd4;
                rd_cnt++;
            end
            if (io_write && io_ready) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", io_addr, e.addr);
                    check("wr_data", io_wdata, e.data);
                end
                wr_cnt++;
            end
        end
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        int          abort_cyc;
        int          stall_rd;
        int          restart_cyc;
        logic [15:0] exp_words;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int  cyc;
        bit  got_done;
        @(negedge pclk);
        salt      = 32'h1357_0000 + 32'(idx);
        src_addr  = v.src;
        dst_addr  = v.dst;
        xfer_len  = v.len;
        stall_idx = v.stall_rd;
        exp_src   = v.src;
        exp_dst   = v.dst;
        rd_cnt    = 0;
        wr_cnt    = 0;
        sb_q.delete();
        start     = 1'b1;
        got_done  = 1'b0;
        cyc       = 0;
        for (int c = 1; c <= 3000 && !got_done; c++) begin
            @(negedge pclk);
            start = (c == v.restart_cyc);
            if (c == v.restart_cyc) begin
                src_addr = 32'hDEAD_0000;
                dst_addr = 32'hBEEF_0000;
                xfer_len = 16'd1;
            end
            abort = (c == v.abort_cyc);
            if (c == 1) check("busy_rise", busy, 1);
            if (done) begin
                got_done = 1'b1;
                cyc      = c;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check("done_seen", got_done, 1);
        check("done_cycle", cyc, v.exp_cycles);
        check("words_done", words_done, v.exp_words);
        check("error", error, v.exp_err);
        check("busy_at_done", busy, 0);
        check("rd_count", rd_cnt, v.exp_words);
        check("wr_count", wr_cnt, v.exp_words);
        check("sb_drained", sb_q.size(), 0);
        @(negedge pclk);
        check("done_one_cycle", done, 0);
        stall_idx = -1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h2000_0000, 16'd3, -1, -1, -1, 16'd3, 1'b0, 14};
        vecs[1] = '{32'h0000_0040, 32'h0000_0080, 16'd0, -1, -1, -1, 16'd0, 1'b0, 2};
        vecs[2] = '{32'h3000_0000, 32'h0000_4000, 16'd4, -1,  1, -1, 16'd1, 1'b1, 1030};
        vecs[3] = '{32'h0000_0500, 32'h0000_0600, 16'd8,  5, -1, -1, 16'd2, 1'b0, 10};
        vecs[4] = '{32'h0000_1000, 32'h0000_2000, 16'd6,  7, -1, -1, 16'd2, 1'b0, 10};
        vecs[5] = '{32'h0000_1100, 32'h0000_2100, 16'd6,  8, -1, -1, 16'd2, 1'b0, 10};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0000_7000, 16'd2, -1, -1,  3, 16'd2, 1'b0, 10};
        vecs[7] = '{32'h0000_0008, 32'h0000_000C, 16'd1, -1, -1, -1, 16'd1, 1'b0, 6};
        vecs[8] = '{32'h0000_0200, 32'h0000_0300, 16'd4,  2, -1, -1, 16'd1, 1'b0, 6};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        xfer_len  = '0;
        salt      = '0;
        stall_idx = -1;
        exp_src   = '0;
        exp_dst   = '0;
        rd_cnt    = 0;
        wr_cnt    = 0;
        repeat (2) @(negedge pclk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words", words_done, 0);
        check("rst_io_read", io_read, 0);
        check("rst_io_write", io_write, 0);
        check("rst_io_addr", io_addr, 0);
        check("rst_io_wdata", io_wdata, 0);
        check("rst_read_ready", read_ready, 0);
        check("rst_burst", {burst, burst_size}, 0);
        check("rst_byte_size", io_byte_size, 2'd3);
        rst_n = 1'b1;

        // Abort while idle must not latch into the following transfer
        @(negedge pclk);
        abort = 1'b1;
        @(negedge pclk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of a write beat
        begin
            bit seen;
            @(negedge pclk);
            salt     = 32'h0BAD_F00D;
            src_addr = 32'h0000_0900;
            dst_addr = 32'h0000_0A00;
            xfer_len = 16'd3;
            exp_src  = src_addr;
            exp_dst  = dst_addr;
            start    = 1'b1;
            @(negedge pclk);
            start = 1'b0;
            seen  = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (io_write) seen = 1'b1;
                else @(negedge pclk);
            end
            check("t6_write_seen", seen, 1);
            #2 rst_n = 1'b0;
            #1;
            check("t6_async_io_write", io_write, 0);
            check("t6_async_busy", busy, 0);
            check("t6_async_io_addr", io_addr, 0);
            @(negedge pclk);
            rst_n = 1'b1;
            @(negedge pclk);
            check("t6_idle_busy", busy, 0);
            check("t6_words_clear", words_done, 0);
            check("t6_no_read", io_read, 0);
            sb_q.delete();
        end
        begin
            vec_t v;
            v = '{32'h0000_0C00, 32'h0000_0D00, 16'd2, -1, -1, -1, 16'd2, 1'b0, 10};
            run_vec(v, 20);
        end

        check("rd_wr_never_both", overlap_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
